// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared edge/center-aligned period counter.
// Period, duty and mode are double-buffered and applied only at period boundaries.
module pwm_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic                    center,
    input  logic [NUM_CH-1:0]       pol,
    input  logic                    load,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    cycle_start,
    output logic                    load_ack
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [CNT_W-1:0]        cnt;
    dir_e                    dir;

    logic [CNT_W-1:0]        period_a;
    logic [NUM_CH*CNT_W-1:0] duty_a;
    logic                    center_a;

    logic [CNT_W-1:0]        period_p;
    logic [NUM_CH*CNT_W-1:0] duty_p;
    logic                    center_p;
    logic                    pend_flag;

    logic [CNT_W-1:0]        cnt_nxt;
    dir_e                    dir_nxt;
    logic                    boundary;
    logic                    xfer;
    logic [NUM_CH-1:0]       raw;

    // Next counter value; boundary marks the cycle whose successor is count 0.
    always_comb begin
        cnt_nxt  = '0;
        dir_nxt  = DIR_UP;
        boundary = 1'b0;
        if (period_a == '0) begin
            boundary = 1'b1;
        end else if (!center_a) begin
            if (cnt >= period_a) begin
                boundary = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (dir == DIR_UP) begin
            if (cnt >= period_a) begin
                // A top of 1 turns straight back to 0, which is itself the boundary.
                if (period_a == CNT_W'(1)) begin
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = period_a - CNT_W'(1);
                    dir_nxt = DIR_DOWN;
                end
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else begin
            if (cnt <= CNT_W'(1)) begin
                boundary = 1'b1;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
                dir_nxt = DIR_DOWN;
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            raw[k] = (cnt < duty_a[k*CNT_W +: CNT_W]);
        end
    end

    // While stopped, pending values need not wait for a period boundary.
    assign xfer = pend_flag && (!en || boundary);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            dir         <= DIR_UP;
            period_a    <= '0;
            duty_a      <= '0;
            center_a    <= 1'b0;
            period_p    <= '0;
            duty_p      <= '0;
            center_p    <= 1'b0;
            pend_flag   <= 1'b0;
            pwm_out     <= '0;
            cycle_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            if (en) begin
                cnt <= cnt_nxt;
                dir <= dir_nxt;
            end else begin
                cnt <= '0;
                dir <= DIR_UP;
            end

            load_ack <= xfer;
            if (xfer) begin
                period_a  <= period_p;
                duty_a    <= duty_p;
                center_a  <= center_p;
                pend_flag <= 1'b0;
            end
            // A load landing on a transfer cycle stays pending for the next boundary.
            if (load) begin
                period_p  <= period;
                duty_p    <= duty;
                center_p  <= center;
                pend_flag <= 1'b1;
            end

            pwm_out     <= en ? (raw ^ pol) : pol;
            cycle_start <= en && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: phase-based reference model, per-cycle scoreboard,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pwm_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W = 8;
  localparam int W = NUM_CH + 2;

  logic                    clk;
  logic                    rst_n;
  logic                    en;
  logic [CNT_W-1:0]        period;
  logic [NUM_CH*CNT_W-1:0] duty;
  logic                    center;
  logic [NUM_CH-1:0]       pol;
  logic                    load;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    cycle_start;
  logic                    load_ack;

  pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .period(period), .duty(duty),
    .center(center), .pol(pol), .load(load), .pwm_out(pwm_out),
    .cycle_start(cycle_start), .load_ack(load_ack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model: position within the period plus active/pending config
  int m_ph;
  int m_p, m_ctr;
  int m_duty[NUM_CH];
  int p_p, p_ctr;
  int p_duty[NUM_CH];
  bit p_flag;
  logic [W-1:0] exp_q[$];

  int obs_hi[NUM_CH];
  int obs_cs, obs_cs_hi, obs_ack, obs_pol;

  function automatic int per_len(int p, int c);
    if (p == 0) return 1;
    return (c != 0) ? 2 * p : p + 1;
  endfunction

  function automatic int ctr_at(int ph, int p, int c);
    if (c != 0 && ph > p) return 2 * p - ph;
    return ph;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_p = 0; m_ctr = 0; p_p = 0; p_ctr = 0; p_flag = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_duty[k] = 0;
      p_duty[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_update();
    logic [NUM_CH-1:0] w;
    bit cs, apply, last;
    int v;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      if (en) begin
        v = ctr_at(m_ph, m_p, m_ctr);
        for (int k = 0; k < NUM_CH; k++) w[k] = (v < m_duty[k]) ^ pol[k];
        cs = (m_ph == 0);
        last = (m_ph == per_len(m_p, m_ctr) - 1);
        m_ph = last ? 0 : m_ph + 1;
        apply = last && p_flag;
      end else begin
        w = pol;
        cs = 1'b0;
        m_ph = 0;
        apply = p_flag;
      end
      if (apply) begin
        m_p = p_p; m_ctr = p_ctr; p_flag = 0;
        for (int k = 0; k < NUM_CH; k++) m_duty[k] = p_duty[k];
      end
      if (load) begin
        p_p = int'(period); p_ctr = int'(center); p_flag = 1;
        for (int k = 0; k < NUM_CH; k++) p_duty[k] = int'(duty[k*CNT_W +: CNT_W]);
      end
      exp_q.push_back({w, cs, apply});
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare for one cycle, sampled on the falling edge
  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    model_update();
    @(negedge clk);
    e = exp_q.pop_front();
    check("pwm_out", 32'(pwm_out), 32'(e[W-1:2]));
    check("cycle_start", 32'(cycle_start), 32'(e[1]));
    check("load_ack", 32'(load_ack), 32'(e[0]));
    for (int k = 0; k < NUM_CH; k++) obs_hi[k] += int'(pwm_out[k]);
    obs_cs += int'(cycle_start);
    obs_cs_hi += int'(cycle_start && pwm_out[0]);
    obs_ack += int'(load_ack);
    obs_pol += int'(pwm_out == pol);
  endtask

  task automatic clear_obs();
    for (int k = 0; k < NUM_CH; k++) obs_hi[k] = 0;
    obs_cs = 0; obs_cs_hi = 0; obs_ack = 0; obs_pol = 0;
  endtask

  task automatic wait_cs(string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = cycle_start;
    end
    check({name, "_cs_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_ack(string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = load_ack;
    end
    check({name, "_ack_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_ph(int target, string name);
    for (int i = 0; i < 40 && m_ph != target; i++) step();
    check({name, "_phase_timeout"}, 32'(m_ph), 32'(target));
  endtask

  task automatic do_load(logic [CNT_W-1:0] p, logic [NUM_CH*CNT_W-1:0] d, logic c);
    period = p; duty = d; center = c; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; period = '0; duty = '0; center = 1'b0;
    pol = 4'b0101; load = 1'b0;
    model_reset();
    clear_obs();

    // reset state
    @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_cs", 32'(cycle_start), 32'd0);
    check("rst_ack", 32'(load_ack), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rel_pwm_pol", 32'(pwm_out), 32'b0101);

    // edge-aligned, period 9, ch0 duty 3
    pol = '0;
    do_load(8'd9, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b0);
    step();
    en = 1'b1;
    wait_cs("edge");
    clear_obs();
    repeat (20) step();
    check("edge_hi0", 32'(obs_hi[0]), 32'd6);
    check("edge_cs", 32'(obs_cs), 32'd2);
    check("edge_cs_align", 32'(obs_cs_hi), 32'd2);

    // duty limits and polarity
    pol = 4'b1000;
    do_load(8'd9, {8'd3, 8'd10, 8'd0, 8'd3}, 1'b0);
    wait_ack("limits");
    wait_cs("limits");
    clear_obs();
    repeat (10) step();
    check("lim_hi1", 32'(obs_hi[1]), 32'd0);
    check("lim_hi2", 32'(obs_hi[2]), 32'd10);
    check("lim_hi3", 32'(obs_hi[3]), 32'd7);

    // shadowed load mid-period
    pol = '0;
    wait_ph(5, "shadow");
    clear_obs();
    do_load(8'd9, {8'd3, 8'd10, 8'd0, 8'd7}, 1'b0);
    check("shadow_early_ack", 32'(obs_ack), 32'd0);
    wait_cs("shadow");
    for (int k = 0; k < NUM_CH; k++) obs_hi[k] = 0;
    repeat (10) step();
    check("shadow_hi0", 32'(obs_hi[0]), 32'd7);
    check("shadow_ack_once", 32'(obs_ack), 32'd1);

    // center-aligned, period 4, ch0 duty 2
    do_load(8'd4, {8'd0, 8'd0, 8'd0, 8'd2}, 1'b1);
    wait_ack("center");
    wait_cs("center");
    clear_obs();
    repeat (16) step();
    check("center_hi0", 32'(obs_hi[0]), 32'd6);
    check("center_cs", 32'(obs_cs), 32'd2);

    // reset mid-period with a pending load
    do_load(8'd9, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b0);
    wait_ack("midrst");
    wait_ph(2, "midrst_a");
    do_load(8'd5, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b1);
    wait_ph(5, "midrst_b");
    pol = 4'b0110;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_pwm", 32'(pwm_out), 32'd0);
    check("midrst_cs", 32'(cycle_start), 32'd0);
    check("midrst_ack", 32'(load_ack), 32'd0);
    step();
    rst_n = 1'b1;
    clear_obs();
    repeat (8) step();
    check("midrst_cs_every", 32'(obs_cs), 32'd8);
    check("midrst_pol", 32'(obs_pol), 32'd8);
    check("midrst_no_ack", 32'(obs_ack), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 15) != 0);
      load = ($urandom_range(0, 9) == 0);
      if (load) begin
        period = CNT_W'($urandom_range(0, 12));
        for (int k = 0; k < NUM_CH; k++) duty[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 14));
        center = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 19) == 0) pol = NUM_CH'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end
      step();
      load = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
